sifh_hist_engine: RTL and testbench
===================================

# sifh_hist_engine

Parametrised successor to the single-pixel SiFH histogram FSM in the dToF readout path. Clears a dual-port histogram RAM shared by 2^PIX_W pixels. Accumulates ACQ_NUM timestamp events by read-modify-write, with same-address forwarding and saturating counts. Then scans every pixel's histogram and reports its peak bin and count to the depth-estimation stage.

## Interface
- BIN_W, 6, bin-address width; 2^BIN_W bins per histogram
- PIX_W, 2, pixel-id width; 2^PIX_W histograms per RAM
- CNT_W, 10, count width; RAM data width
- ACQ_NUM, 1024, events accepted per frame (≥1)
- clk  in  1  single clock; all logic on rising edge
- res  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins frame; ignored unless IDLE
- ts_valid  in  1  event valid
- ts_ready  out  1  event accepted when ts_valid & ts_ready
- ts_bin  in  BIN_W  timestamp bin
- ts_pix  in  PIX_W  pixel id
- ram_we  out  1  write enable (port A)
- ram_waddr  out  PIX_W+BIN_W  write address {pix,bin}
- ram_wdata  out  CNT_W  write data
- ram_re  out  1  read enable (port B)
- ram_raddr  out  PIX_W+BIN_W  read address
- ram_rdata  in  CNT_W  read data, valid 1 cycle after ram_re; same-cycle read-during-write returns old data
- pk_valid  out  1  one-cycle peak strobe
- pk_pix  out  PIX_W  pixel of reported peak
- pk_bin  out  BIN_W  peak bin
- pk_cnt  out  CNT_W  peak count
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE → CLEAR → ACCUM → DRAIN → PEAK → DONE → IDLE.
- IDLE: all strobes low. start=1 → CLEAR.
- CLEAR: ram_we=1, ram_wdata=0. Address steps 0..2^(PIX_W+BIN_W)-1, one per cycle. After the last address → ACCUM. ts_ready=0.
- ACCUM, stage 1: ts_ready=1 until ACQ_NUM events are accepted. An accepted event drives ram_re=1 and ram_raddr={ts_pix,ts_bin} in the same cycle; its address and a valid bit are registered.
- ACCUM, stage 2 (next cycle): old = forwarded value if flagged, else ram_rdata. Write ram_waddr=stage-1 address, ram_wdata=min(old+1, 2^CNT_W-1), ram_we=1.
- Forwarding: if a stage-1 read address equals the stage-2 write address in the same cycle, stage 1 records the stage-2 write value and uses it instead of ram_rdata. Back-to-back identical events therefore count correctly with no stall.
- Event counter reaching ACQ_NUM → ts_ready drops the following cycle → DRAIN.
- DRAIN: one cycle; completes the last stage-2 write; no reads.
- PEAK: reads addresses 0..2^(PIX_W+BIN_W)-1 sequentially, one per cycle; compares one cycle after each read.
  - Running max per pixel is reset at bin 0.
  - Update only on strictly greater, so ties keep the lowest bin.
  - All-zero histogram reports bin 0, count 0.
  - After a pixel's last bin is compared: pk_valid=1 for one cycle with pk_pix, pk_bin, pk_cnt; these are held until the next strobe.
  - After the last pixel is reported → DONE.
- DONE: done=1 for one cycle → IDLE. RAM retains the histograms.
- Reset in any state: state IDLE; all outputs 0 (ts_ready, ram_we, ram_re, addresses, ram_wdata, pk_*, busy, done); counters and pipeline cleared. RAM contents are left undefined; the next frame's CLEAR restores them.
- ts_valid while ts_ready=0: the event is not accepted. The source holds it.

## Timing
- start at cycle 0 → busy=1 and first clear write at cycle 1.
- CLEAR lasts N=2^(PIX_W+BIN_W) cycles.
- ACCUM lasts ACQ_NUM cycles plus source stall cycles; event write occurs 1 cycle after acceptance.
- DRAIN: 1 cycle.
- PEAK: N+1 cycles. pk_valid for pixel p occurs 2 cycles after reading address p·2^BIN_W+2^BIN_W-1.
- DONE: 1 cycle.
- Minimum frame with ts_valid held high: 2N+ACQ_NUM+3 cycles from start to done.
- ram_we and ram_re are never high outside CLEAR/ACCUM/DRAIN/PEAK. No RAM write occurs during PEAK.

## Test plan
- Reset: assert res mid-cycle → all outputs 0 asynchronously, busy=0. Release, no start → no RAM activity for 100 cycles.
- Clear: defaults, start → exactly 256 writes of 0 at addresses 0..255, then ts_ready=1.
- Forwarding: ACQ_NUM=8; 5 back-to-back events pix=1 bin=7, then 3 events pix=2 bin=0 → pk_pix=1 bin=7 cnt=5; pk_pix=2 bin=0 cnt=3; pixels 0 and 3 report bin 0 cnt 0.
- Saturation: CNT_W=3, ACQ_NUM=9, all events pix=0 bin=4 → final write value 7; pk_cnt=7.
- Tie and gaps: ACQ_NUM=4; events pix=3 bin 10, 20, 20, 10 with ts_valid gaps of 2 cycles → pk_pix=3 bin=10 cnt=2.
- Reset mid-ACCUM after 3 events, then start → full CLEAR re-executes; the new frame's peaks reflect only new events; done pulses once.

Source files
------------

// File: rtl/sifh_hist_engine.sv
// Multi-pixel SiFH histogram engine: clears a shared histogram RAM, accumulates
// timestamp events with read-modify-write and forwarding, then reports per-pixel peaks.
module sifh_hist_engine #(
  parameter int BIN_W   = 6,
  parameter int PIX_W   = 2,
  parameter int CNT_W   = 10,
  parameter int ACQ_NUM = 1024
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   start,
  input  logic                   ts_valid,
  output logic                   ts_ready,
  input  logic [BIN_W-1:0]       ts_bin,
  input  logic [PIX_W-1:0]       ts_pix,
  output logic                   ram_we,
  output logic [PIX_W+BIN_W-1:0] ram_waddr,
  output logic [CNT_W-1:0]       ram_wdata,
  output logic                   ram_re,
  output logic [PIX_W+BIN_W-1:0] ram_raddr,
  input  logic [CNT_W-1:0]       ram_rdata,
  output logic                   pk_valid,
  output logic [PIX_W-1:0]       pk_pix,
  output logic [BIN_W-1:0]       pk_bin,
  output logic [CNT_W-1:0]       pk_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam int AW  = PIX_W + BIN_W;
  localparam int ACW = $clog2(ACQ_NUM + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_PEAK  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_reg, state_next;
  logic [AW-1:0]    clr_addr_reg;
  logic [ACW-1:0]   acc_cnt_reg;
  logic [AW:0]      scan_cnt_reg;
  logic             s1_valid_reg;
  logic [AW-1:0]    s1_addr_reg;
  logic             fwd_reg;
  logic [CNT_W-1:0] fwd_val_reg;
  logic             cmp_valid_reg;
  logic [AW-1:0]    cmp_addr_reg;
  logic [CNT_W-1:0] max_cnt_reg;
  logic [BIN_W-1:0] max_bin_reg;

  logic             accept;
  logic [AW-1:0]    ev_addr;
  logic [CNT_W-1:0] old_cnt;
  logic [CNT_W-1:0] inc_cnt;
  logic             stage2_we;
  logic             scan_rd;
  logic [BIN_W-1:0] cmp_bin;
  logic             take;
  logic [CNT_W-1:0] new_cnt;
  logic [BIN_W-1:0] new_bin;
  logic             last_cmp;

  assign accept    = (state_reg == S_ACCUM) && ts_valid;
  assign ev_addr   = {ts_pix, ts_bin};
  // RAM returns stale data on read-during-write, so a just-written count is forwarded.
  assign old_cnt   = fwd_reg ? fwd_val_reg : ram_rdata;
  assign inc_cnt   = (old_cnt == {CNT_W{1'b1}}) ? old_cnt : old_cnt + 1'b1;
  assign stage2_we = ((state_reg == S_ACCUM) || (state_reg == S_DRAIN)) && s1_valid_reg;
  assign scan_rd   = (state_reg == S_PEAK) && !scan_cnt_reg[AW];

  // Bin 0 always loads the running max; later bins only win when strictly greater.
  assign cmp_bin   = cmp_addr_reg[BIN_W-1:0];
  assign take      = (cmp_bin == '0) || (ram_rdata > max_cnt_reg);
  assign new_cnt   = take ? ram_rdata : max_cnt_reg;
  assign new_bin   = take ? cmp_bin : max_bin_reg;
  assign last_cmp  = cmp_valid_reg && (&cmp_addr_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_CLEAR;
      S_CLEAR: if (&clr_addr_reg) state_next = S_ACCUM;
      S_ACCUM: if (accept && (acc_cnt_reg == ACW'(ACQ_NUM - 1))) state_next = S_DRAIN;
      S_DRAIN: state_next = S_PEAK;
      S_PEAK:  if (last_cmp) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ts_ready  = (state_reg == S_ACCUM);
    busy      = (state_reg != S_IDLE);
    done      = (state_reg == S_DONE);
    ram_re    = accept || scan_rd;
    ram_raddr = '0;
    if (accept)
      ram_raddr = ev_addr;
    else if (scan_rd)
      ram_raddr = scan_cnt_reg[AW-1:0];
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (state_reg == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_reg;
    end else if (stage2_we) begin
      ram_we    = 1'b1;
      ram_waddr = s1_addr_reg;
      ram_wdata = inc_cnt;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_reg     <= S_IDLE;
      clr_addr_reg  <= '0;
      acc_cnt_reg   <= '0;
      scan_cnt_reg  <= '0;
      s1_valid_reg  <= 1'b0;
      s1_addr_reg   <= '0;
      fwd_reg       <= 1'b0;
      fwd_val_reg   <= '0;
      cmp_valid_reg <= 1'b0;
      cmp_addr_reg  <= '0;
      max_cnt_reg   <= '0;
      max_bin_reg   <= '0;
      pk_valid      <= 1'b0;
      pk_pix        <= '0;
      pk_bin        <= '0;
      pk_cnt        <= '0;
    end else begin
      state_reg     <= state_next;
      clr_addr_reg  <= (state_reg == S_CLEAR) ? clr_addr_reg + 1'b1 : '0;
      if (state_reg == S_IDLE)
        acc_cnt_reg <= '0;
      else if (accept)
        acc_cnt_reg <= acc_cnt_reg + 1'b1;
      if (scan_rd)
        scan_cnt_reg <= scan_cnt_reg + 1'b1;
      else if (state_reg != S_PEAK)
        scan_cnt_reg <= '0;
      s1_valid_reg  <= accept;
      s1_addr_reg   <= ev_addr;
      fwd_reg       <= accept && stage2_we && (ev_addr == s1_addr_reg);
      fwd_val_reg   <= inc_cnt;
      cmp_valid_reg <= scan_rd;
      cmp_addr_reg  <= scan_cnt_reg[AW-1:0];
      if (cmp_valid_reg) begin
        max_cnt_reg <= new_cnt;
        max_bin_reg <= new_bin;
      end
      pk_valid <= cmp_valid_reg && (&cmp_bin);
      if (cmp_valid_reg && (&cmp_bin)) begin
        pk_pix <= cmp_addr_reg[AW-1:BIN_W];
        pk_bin <= new_bin;
        pk_cnt <= new_cnt;
      end
    end
  end

endmodule

// File: tb/tb_sifh_hist_engine.sv
// Bench for sifh_hist_engine: RAM model, frame-timeline reference checker,
// directed frames (saturation, ties, forwarding, reset) and random frames.
module tb_sifh_hist_engine;
  localparam int BIN_W = 4;
  localparam int PIX_W = 2;
  localparam int CNT_W = 3;
  localparam int ACQ   = 12;
  localparam int B     = 1 << BIN_W;
  localparam int P     = 1 << PIX_W;
  localparam int N     = B * P;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 0;
  logic res = 1;
  logic start = 0;
  logic ts_valid = 0;
  logic ts_ready;
  logic [BIN_W-1:0] ts_bin = '0;
  logic [PIX_W-1:0] ts_pix = '0;
  logic ram_we, ram_re;
  logic [PIX_W+BIN_W-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0] ram_wdata;
  logic [CNT_W-1:0] ram_rdata = '0;
  logic pk_valid;
  logic [PIX_W-1:0] pk_pix;
  logic [BIN_W-1:0] pk_bin;
  logic [CNT_W-1:0] pk_cnt;
  logic busy, done;

  int checks = 0;
  int errors = 0;

  sifh_hist_engine #(.BIN_W(BIN_W), .PIX_W(PIX_W), .CNT_W(CNT_W), .ACQ_NUM(ACQ)) dut (
    .clk(clk), .res(res), .start(start), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .ts_bin(ts_bin), .ts_pix(ts_pix), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .pk_valid(pk_valid), .pk_pix(pk_pix), .pk_bin(pk_bin), .pk_cnt(pk_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Dual-port RAM: registered read returning old data on same-cycle write.
  logic [CNT_W-1:0] mem [N];
  initial for (int i = 0; i < N; i++) mem[i] = CNT_W'($urandom);
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: histogram of accepted events and a frame timeline.
  int hist [N];
  int ph = 0;             // 0 idle,1 clear,2 accum,3 drain,4 peak,5 done
  int k, nacc, j;
  bit pend = 0;
  int pend_addr;
  int seen_bin [P];
  int seen_cnt [P];

  function automatic void model_peak(input int p, output int bb, output int bc);
    bb = 0; bc = 0;
    for (int b = 0; b < B; b++)
      if (hist[p*B+b] > bc) begin bc = hist[p*B+b]; bb = b; end
  endfunction

  task automatic chk_pend_write();
    int e;
    chk("s2_we", ram_we, pend);
    if (pend) begin
      e = (hist[pend_addr] + 1 > CMAX) ? CMAX : hist[pend_addr] + 1;
      chk("s2_waddr", ram_waddr, pend_addr);
      chk("s2_wdata", ram_wdata, e);
      hist[pend_addr] = e;
    end
    pend = 0;
  endtask

  task automatic chk_peak(input int p);
    int bb, bc;
    model_peak(p, bb, bc);
    chk("pk_pix", pk_pix, p);
    chk("pk_bin", pk_bin, bb);
    chk("pk_cnt", pk_cnt, bc);
  endtask

  always @(negedge clk) begin
    if (res) begin
      ph = 0; pend = 0;
    end else begin
      if (pk_valid) begin seen_bin[pk_pix] = pk_bin; seen_cnt[pk_pix] = pk_cnt; end
      case (ph)
        0: begin
          chk("idle_ctl", {busy, ram_we, ram_re, ts_ready, done, pk_valid}, 6'b0);
          if (start) begin ph = 1; k = 0; end
        end
        1: begin
          chk("clr_ctl", {busy, ram_we, ram_re, ts_ready, done}, 5'b11000);
          chk("clr_addr", ram_waddr, k);
          chk("clr_data", ram_wdata, 0);
          k++;
          if (k == N) begin
            ph = 2; nacc = 0;
            for (int i = 0; i < N; i++) hist[i] = 0;
          end
        end
        2: begin
          chk("acc_ctl", {busy, ts_ready, done, pk_valid}, 4'b1100);
          chk_pend_write();
          chk("acc_re", ram_re, ts_valid);
          if (ts_valid) begin
            chk("acc_raddr", ram_raddr, {ts_pix, ts_bin});
            pend = 1; pend_addr = {ts_pix, ts_bin};
            nacc++;
            if (nacc == ACQ) ph = 3;
          end
        end
        3: begin
          chk("drain_ctl", {busy, ts_ready, ram_re, done}, 4'b1000);
          chk("drain_pend", pend, 1);
          chk_pend_write();
          ph = 4; j = 0;
        end
        4: begin
          bit pkx;
          chk("peak_ctl", {busy, ts_ready, ram_we, done}, 4'b1000);
          chk("peak_re", ram_re, j < N);
          if (j < N) chk("peak_raddr", ram_raddr, j);
          pkx = (j >= 2) && ((j - 2) % B == B - 1);
          chk("peak_strobe", pk_valid, pkx);
          if (pkx) chk_peak((j - 2) / B);
          j++;
          if (j == N + 1) ph = 5;
        end
        default: begin
          chk("done_ctl", {busy, ram_we, ram_re, ts_ready, done, pk_valid}, 6'b100011);
          chk_peak(P - 1);
          ph = 0;
        end
      endcase
    end
  end

  task automatic send(input int pix, input int bin, input int gap);
    bit acc = 0;
    ts_pix = PIX_W'(pix); ts_bin = BIN_W'(bin); ts_valid = 1;
    for (int w = 0; w < 400 && !acc; w++) begin
      @(negedge clk); acc = ts_ready;
      @(posedge clk); #1;
    end
    chk("send_accepted", acc, 1);
    if (gap > 0) begin
      ts_valid = 0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic pulse_start();
    for (int p = 0; p < P; p++) begin seen_bin[p] = -1; seen_cnt[p] = -1; end
    start = 1; @(posedge clk); #1; start = 0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    ts_valid = 0;
    for (int w = 0; w < 1000 && !seen; w++) begin @(negedge clk); seen = done; end
    chk("done_seen", seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic expect_lit(input int p, input int bb, input int bc);
    chk("lit_bin", seen_bin[p], bb);
    chk("lit_cnt", seen_cnt[p], bc);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 res = 0;
    repeat (100) begin @(posedge clk); #1; end

    // Saturation at pixel 0 plus a tie with gaps at pixel 3.
    pulse_start();
    for (int i = 0; i < 8; i++) send(0, 4, 0);
    send(3, 10, 2); send(3, 14, 2); send(3, 14, 2); send(3, 10, 0);
    wait_done();
    $display("frame sat/tie: pix0 %0d/%0d pix3 %0d/%0d", seen_bin[0], seen_cnt[0], seen_bin[3], seen_cnt[3]);
    expect_lit(0, 4, 7); expect_lit(1, 0, 0); expect_lit(2, 0, 0); expect_lit(3, 10, 2);

    // Forwarding: back-to-back identical events.
    pulse_start();
    for (int i = 0; i < 5; i++) send(1, 7, 0);
    for (int i = 0; i < 3; i++) send(2, 0, 0);
    for (int i = 0; i < 4; i++) send(1, 2, 0);
    wait_done();
    $display("frame fwd: pix1 %0d/%0d pix2 %0d/%0d", seen_bin[1], seen_cnt[1], seen_bin[2], seen_cnt[2]);
    expect_lit(0, 0, 0); expect_lit(1, 7, 5); expect_lit(2, 0, 3); expect_lit(3, 0, 0);

    // Asynchronous reset mid-accumulation, then a fresh frame.
    pulse_start();
    send(2, 5, 0); send(2, 5, 0); send(2, 6, 1);
    #2 res = 1;
    #1 chk("rst_async", {ts_ready, ram_we, ram_re, ram_waddr, ram_raddr, ram_wdata,
                         pk_valid, pk_pix, pk_bin, pk_cnt, busy, done}, 0);
    @(posedge clk); #1 res = 0;
    repeat (5) begin @(posedge clk); #1; end
    pulse_start();
    for (int i = 0; i < ACQ; i++) send(1, 3, i % 3);
    wait_done();
    $display("frame post-reset: pix1 %0d/%0d pix2 %0d/%0d", seen_bin[1], seen_cnt[1], seen_bin[2], seen_cnt[2]);
    expect_lit(1, 3, 7); expect_lit(2, 0, 0);

    // Random frames biased towards repeated addresses.
    for (int f = 0; f < 5; f++) begin
      pulse_start();
      for (int i = 0; i < ACQ; i++) begin
        int pix, bin, gap;
        pix = $urandom_range(0, P - 1);
        bin = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, B - 1);
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        send(pix, bin, gap);
      end
      wait_done();
      $display("random frame %0d: peaks %0d/%0d %0d/%0d %0d/%0d %0d/%0d", f,
               seen_bin[0], seen_cnt[0], seen_bin[1], seen_cnt[1],
               seen_bin[2], seen_cnt[2], seen_bin[3], seen_cnt[3]);
    end

    repeat (20) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
